// File: rtl/ps2_kbd_pkg.sv
// Shared constants and types for the PS/2 keyboard-to-joystick block:
// scan codes, joystick bit positions, receiver state encoding and the
// key lookup used by the decoder.
package ps2_kbd_pkg;

   localparam int KJ_W = 10;

   // Prefix / special scan codes
   localparam logic [7:0] SC_E0    = 8'hE0;
   localparam logic [7:0] SC_F0    = 8'hF0;
   localparam logic [7:0] SC_E1    = 8'hE1;

   // Mapped scan codes (UP..RIGHT are only valid after an E0 prefix)
   localparam logic [7:0] SC_SPACE = 8'h29;
   localparam logic [7:0] SC_1     = 8'h16;
   localparam logic [7:0] SC_2     = 8'h1E;
   localparam logic [7:0] SC_5     = 8'h2E;
   localparam logic [7:0] SC_UP    = 8'h75;
   localparam logic [7:0] SC_DOWN  = 8'h72;
   localparam logic [7:0] SC_LEFT  = 8'h6B;
   localparam logic [7:0] SC_RIGHT = 8'h74;
   localparam logic [7:0] SC_LCTRL = 8'h14;
   localparam logic [7:0] SC_TAB   = 8'h0D;

   // Bit positions inside the joystick vector
   localparam logic [3:0] KJ_FIRE    = 4'd0;
   localparam logic [3:0] KJ_START1  = 4'd1;
   localparam logic [3:0] KJ_START2  = 4'd2;
   localparam logic [3:0] KJ_COIN    = 4'd3;
   localparam logic [3:0] KJ_UP      = 4'd4;
   localparam logic [3:0] KJ_DOWN    = 4'd5;
   localparam logic [3:0] KJ_LEFT    = 4'd6;
   localparam logic [3:0] KJ_RIGHT   = 4'd7;
   localparam logic [3:0] KJ_FIRE2   = 4'd8;
   localparam logic [3:0] KJ_SERVICE = 4'd9;

   typedef enum logic [1:0] {
      PS2_IDLE   = 2'd0,
      PS2_DATA   = 2'd1,
      PS2_PARITY = 2'd2,
      PS2_STOP   = 2'd3
   } ps2_rx_state_t;

   typedef struct packed {
      logic       hit;
      logic [3:0] idx;
   } key_map_t;

   // Look up a scan code; extended codes only match with ext set and vice versa
   function automatic key_map_t key_map(input logic [7:0] code, input logic ext);
      key_map_t r;
      r.hit = 1'b1;
      r.idx = 4'd0;
      case ({ext, code})
         {1'b0, SC_SPACE}: r.idx = KJ_FIRE;
         {1'b0, SC_1}:     r.idx = KJ_START1;
         {1'b0, SC_2}:     r.idx = KJ_START2;
         {1'b0, SC_5}:     r.idx = KJ_COIN;
         {1'b1, SC_UP}:    r.idx = KJ_UP;
         {1'b1, SC_DOWN}:  r.idx = KJ_DOWN;
         {1'b1, SC_LEFT}:  r.idx = KJ_LEFT;
         {1'b1, SC_RIGHT}: r.idx = KJ_RIGHT;
         {1'b0, SC_LCTRL}: r.idx = KJ_FIRE2;
         {1'b0, SC_TAB}:   r.idx = KJ_SERVICE;
         default:          r.hit = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 device-to-host frame receiver: input synchronisers, falling-edge
// detector, IDLE/DATA/PARITY/STOP frame FSM and an inactivity watchdog.
// Strobe outputs are combinational and coincide with the edge/timeout that
// causes them; the top level registers them.
// Build option: define PS2_PARITY_EN to reject frames with even parity.
module ps2_rx
   import ps2_kbd_pkg::*;
#(
   parameter int SYNC_STAGES    = 2,
   parameter int TIMEOUT_CYCLES = 36000
) (
   input  logic       clk_i,
   input  logic       res_n_i,
   input  logic       ps2_clk_i,
   input  logic       ps2_data_i,
   output logic       byte_valid_o,
   output logic [7:0] byte_data_o,
   output logic       frame_err_o,
   output logic       timeout_o
);

   localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES - 1);

   logic [SYNC_STAGES-1:0] clk_sync_q;
   logic [SYNC_STAGES-1:0] data_sync_q;
   logic                   clk_prev_q;
   ps2_rx_state_t          state_q;
   logic [2:0]             cnt_q;
   logic [7:0]             shift_q;
   logic [WD_W-1:0]        wd_q;
`ifdef PS2_PARITY_EN
   logic                   par_q;
`endif

   logic clk_s;
   logic data_s;
   logic fall;
   logic frame_ok;
   logic wd_fire;

   assign clk_s  = clk_sync_q[SYNC_STAGES-1];
   assign data_s = data_sync_q[SYNC_STAGES-1];
   assign fall   = clk_prev_q & ~clk_s;

`ifdef PS2_PARITY_EN
   assign frame_ok = data_s & (^{shift_q, par_q});
`else
   assign frame_ok = data_s;
`endif

   // A falling edge restarts the watchdog, so a timeout never races an edge
   assign wd_fire      = (state_q != PS2_IDLE) && !fall && (wd_q == WD_LIMIT);
   assign byte_valid_o = fall && (state_q == PS2_STOP) && frame_ok;
   assign frame_err_o  = (fall && (state_q == PS2_STOP) && !frame_ok) || wd_fire;
   assign timeout_o    = wd_fire;
   assign byte_data_o  = shift_q;

   // Synchronisers, frame FSM, shift register and watchdog
   always_ff @(posedge clk_i or negedge res_n_i) begin
      // NOTE: every register here is small control state, so all of it takes
      // the async reset; sync flops reset low so a line that is already high
      // at release cannot look like a falling edge.
      if (!res_n_i) begin
         clk_sync_q  <= '0;
         data_sync_q <= '0;
         clk_prev_q  <= 1'b0;
         state_q     <= PS2_IDLE;
         cnt_q       <= '0;
         shift_q     <= '0;
         wd_q        <= '0;
`ifdef PS2_PARITY_EN
         par_q       <= 1'b0;
`endif
      end else begin
         // NOTE: non-blocking assignments keep every flop sampling the
         // pre-edge value, which is what makes the sync chain a real chain.
         clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk_i};
         data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data_i};
         clk_prev_q  <= clk_s;

         if (fall || (state_q == PS2_IDLE) || wd_fire) begin
            wd_q <= '0;
         end else begin
            wd_q <= wd_q + 1'b1;
         end

         if (wd_fire) begin
            state_q <= PS2_IDLE;
         end else if (fall) begin
            unique case (state_q)
               PS2_IDLE: begin
                  if (!data_s) begin
                     state_q <= PS2_DATA;
                     cnt_q   <= '0;
                  end
               end
               PS2_DATA: begin
                  shift_q[cnt_q] <= data_s;
                  cnt_q          <= cnt_q + 3'd1;
                  if (cnt_q == 3'd7) begin
                     state_q <= PS2_PARITY;
                  end
               end
               PS2_PARITY: begin
`ifdef PS2_PARITY_EN
                  par_q   <= data_s;
`endif
                  state_q <= PS2_STOP;
               end
               PS2_STOP: begin
                  state_q <= PS2_IDLE;
               end
               default: state_q <= PS2_IDLE;
            endcase
         end
      end
   end

endmodule

// File: rtl/ps2_kbd_joy.sv
// PS/2 keyboard to 10-bit joystick latch vector. Tracks the E0 (extended)
// and F0 (break) prefixes and keeps one press/release latch per mapped key.
// Build option: define PS2_PARITY_EN to enable odd-parity checking in ps2_rx.
module ps2_kbd_joy
   import ps2_kbd_pkg::*;
#(
   parameter int SYNC_STAGES    = 2,
   parameter int TIMEOUT_CYCLES = 36000
) (
   input  logic            clk_i,
   input  logic            res_n_i,
   input  logic            ps2_kbd_clk,
   input  logic            ps2_kbd_data,
   output logic [KJ_W-1:0] joystick,
   output logic            scan_valid,
   output logic [7:0]      scan_code,
   output logic            frame_err
);

   logic       rx_valid;
   logic [7:0] rx_data;
   logic       rx_err;
   logic       rx_timeout;

   ps2_rx #(
      .SYNC_STAGES   (SYNC_STAGES),
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_rx (
      .clk_i       (clk_i),
      .res_n_i     (res_n_i),
      .ps2_clk_i   (ps2_kbd_clk),
      .ps2_data_i  (ps2_kbd_data),
      .byte_valid_o(rx_valid),
      .byte_data_o (rx_data),
      .frame_err_o (rx_err),
      .timeout_o   (rx_timeout)
   );

   logic [KJ_W-1:0] joy_q, joy_d;
   logic            ext_q, ext_d;
   logic            brk_q, brk_d;
   logic            scan_valid_q;
   logic [7:0]      scan_code_q;
   logic            frame_err_q;
   key_map_t        km;

   // Prefix tracking and key latch update for each accepted byte
   always_comb begin
      // NOTE: defaults first so every path assigns every variable (no latches).
      joy_d = joy_q;
      ext_d = ext_q;
      brk_d = brk_q;
      km    = key_map(rx_data, ext_q);
      if (rx_timeout) begin
         ext_d = 1'b0;
         brk_d = 1'b0;
      end else if (rx_valid) begin
         case (rx_data)
            SC_E0: ext_d = 1'b1;
            SC_F0: brk_d = 1'b1;
            SC_E1: ;  // Pause prefix: accepted, no effect
            default: begin
               if (km.hit) begin
                  joy_d[km.idx] = ~brk_q;
               end
               ext_d = 1'b0;
               brk_d = 1'b0;
            end
         endcase
      end
   end

   // Registered outputs and decoder state
   always_ff @(posedge clk_i or negedge res_n_i) begin
      if (!res_n_i) begin
         joy_q        <= '0;
         ext_q        <= 1'b0;
         brk_q        <= 1'b0;
         scan_valid_q <= 1'b0;
         scan_code_q  <= '0;
         frame_err_q  <= 1'b0;
      end else begin
         joy_q        <= joy_d;
         ext_q        <= ext_d;
         brk_q        <= brk_d;
         scan_valid_q <= rx_valid;
         frame_err_q  <= rx_err;
         if (rx_valid) begin
            scan_code_q <= rx_data;
         end
      end
   end

   assign joystick   = joy_q;
   assign scan_valid = scan_valid_q;
   assign scan_code  = scan_code_q;
   assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_ps2_kbd_joy.sv
// Directed testbench for ps2_kbd_joy. The PS/2 clock is scaled up and the
// watchdog shortened so the run stays short; expectations follow either
// setting of PS2_PARITY_EN.
`timescale 1ns/1ps
module tb_ps2_kbd_joy;
   import ps2_kbd_pkg::*;

   localparam int TIMEOUT = 300;
   localparam int HALF    = 200;  // PS/2 half bit period in ns (20 clk cycles)

   logic       clk = 1'b0;
   logic       res_n = 1'b0;
   logic       ps2_clk = 1'b1;
   logic       ps2_data = 1'b1;
   logic [9:0] joystick;
   logic       scan_valid;
   logic [7:0] scan_code;
   logic       frame_err;

   int errors = 0;
   int checks = 0;
   int sv_cnt = 0;
   int fe_cnt = 0;
   logic [7:0] sv_log [0:255];

   always #5 clk = ~clk;

   ps2_kbd_joy #(
      .SYNC_STAGES   (2),
      .TIMEOUT_CYCLES(TIMEOUT)
   ) dut (
      .clk_i       (clk),
      .res_n_i     (res_n),
      .ps2_kbd_clk (ps2_clk),
      .ps2_kbd_data(ps2_data),
      .joystick    (joystick),
      .scan_valid  (scan_valid),
      .scan_code   (scan_code),
      .frame_err   (frame_err)
   );

   // Pulse monitor, sampled away from the active edge
   always @(negedge clk) begin
      if (scan_valid) begin
         sv_log[sv_cnt[7:0]] <= scan_code;
         sv_cnt <= sv_cnt + 1;
      end
      if (frame_err) fe_cnt <= fe_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [10:0] mkframe(input logic [7:0] b, input logic bad_par);
      logic par;
      par = ~(^b) ^ bad_par;
      return {1'b1, par, b, 1'b0};
   endfunction

   task automatic ps2_bits(input logic [10:0] fr, input int first, input int last);
      for (int i = first; i <= last; i++) begin
         ps2_data = fr[i];
         #(HALF);
         ps2_clk = 1'b0;
         #(HALF);
         ps2_clk = 1'b1;
      end
   endtask

   task automatic send(input logic [7:0] b, input logic bad_par = 1'b0);
      ps2_bits(mkframe(b, bad_par), 0, 10);
      ps2_data = 1'b1;
      #(2 * HALF);
   endtask

   int base;
   int fe_exp;

   initial begin
      fe_exp = 0;
      #23;
      @(negedge clk);
      check("reset_joystick", 32'(joystick), 32'h0);
      check("reset_scan_valid", 32'(scan_valid), 32'h0);
      check("reset_scan_code", 32'(scan_code), 32'h0);
      check("reset_frame_err", 32'(frame_err), 32'h0);
      res_n = 1'b1;
      repeat (5) @(posedge clk);

      // Space press / release
      base = sv_cnt;
      send(8'h29);
      @(negedge clk);
      check("space_press", 32'(joystick), 32'h001);
      send(8'hF0);
      send(8'h29);
      @(negedge clk);
      check("space_release", 32'(joystick), 32'h000);
      check("space_pulses", 32'(sv_cnt - base), 32'd3);
      check("space_code0", 32'(sv_log[base[7:0]]), 32'h29);
      check("space_code1", 32'(sv_log[8'(base + 1)]), 32'hF0);
      check("space_code2", 32'(sv_log[8'(base + 2)]), 32'h29);
      check("scan_code_held", 32'(scan_code), 32'h29);

      // Extended up, bare 75 must not match
      send(8'hE0);
      send(8'h75);
      @(negedge clk);
      check("up_press", 32'(joystick), 32'h010);
      send(8'h75);
      @(negedge clk);
      check("bare_75", 32'(joystick), 32'h010);
      send(8'hE0);
      send(8'hF0);
      send(8'h75);
      @(negedge clk);
      check("up_release", 32'(joystick), 32'h000);

      // Multi-key hold
      send(8'h16);
      send(8'h1E);
      send(8'hE0);
      send(8'h6B);
      @(negedge clk);
      check("hold_three", 32'(joystick), 32'h046);
      send(8'hF0);
      send(8'h1E);
      @(negedge clk);
      check("release_1e", 32'(joystick), 32'b0001000010);
      send(8'hF0);
      send(8'h16);
      send(8'hE0);
      send(8'hF0);
      send(8'h6B);
      @(negedge clk);
      check("all_released", 32'(joystick), 32'h000);

      // Corrupted parity
      base = sv_cnt;
      send(8'h29, 1'b1);
      @(negedge clk);
`ifdef PS2_PARITY_EN
      fe_exp++;
      check("badpar_joystick", 32'(joystick), 32'h000);
      check("badpar_no_valid", 32'(sv_cnt - base), 32'd0);
`else
      check("badpar_joystick", 32'(joystick), 32'h001);
      check("badpar_valid", 32'(sv_cnt - base), 32'd1);
      send(8'hF0);
      send(8'h29);
      @(negedge clk);
      check("badpar_clear", 32'(joystick), 32'h000);
`endif
      check("badpar_frame_err", 32'(fe_cnt), 32'(fe_exp));

      // Watchdog: 4 bits then silence
      ps2_bits(mkframe(8'h00, 1'b0), 0, 3);
      ps2_data = 1'b1;
      repeat (TIMEOUT + 20) @(posedge clk);
      @(negedge clk);
      fe_exp++;
      check("timeout_frame_err", 32'(fe_cnt), 32'(fe_exp));
      check("timeout_idle", 32'(dut.u_rx.state_q), 32'(PS2_IDLE));
      send(8'h2E);
      @(negedge clk);
      check("coin_after_timeout", 32'(joystick), 32'h008);
      send(8'hF0);
      send(8'h2E);

      // Reset mid-frame with right held
      send(8'hE0);
      send(8'h74);
      @(negedge clk);
      check("right_press", 32'(joystick), 32'h080);
      ps2_bits(mkframe(8'h29, 1'b0), 0, 4);
      #(HALF / 2);
      res_n = 1'b0;
      #1;
      check("rst_joystick", 32'(joystick), 32'h000);
      check("rst_scan_code", 32'(scan_code), 32'h00);
      check("rst_scan_valid", 32'(scan_valid), 32'h0);
      check("rst_frame_err", 32'(frame_err), 32'h0);
      #20;
      res_n = 1'b1;
      base = sv_cnt;
      ps2_bits(mkframe(8'h29, 1'b0), 5, 10);
      ps2_data = 1'b1;
      repeat (TIMEOUT + 20) @(posedge clk);
      @(negedge clk);
      fe_exp++;
      check("rst_tail_no_valid", 32'(sv_cnt - base), 32'd0);
      check("rst_tail_timeout", 32'(fe_cnt), 32'(fe_exp));
      send(8'h0D);
      @(negedge clk);
      check("service_press", 32'(joystick), 32'h200);
      check("service_code", 32'(scan_code), 32'h0D);

      // Pause sequence fragment: E1 14 F0 14 nets to nothing
      send(8'hE1);
      send(8'h14);
      @(negedge clk);
      check("pause_ctrl_press", 32'(joystick), 32'h300);
      send(8'hF0);
      send(8'h14);
      @(negedge clk);
      check("pause_net_none", 32'(joystick), 32'h200);
      check("frame_err_total", 32'(fe_cnt), 32'(fe_exp));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
